counter_sequencer: RTL and testbench
====================================

// Module: counter_sequencer
// PURPOSE
//  Initiator side of the up-counter load/inc/done interface. Accepts a start value on a
//  valid/ready request port, pulses cnt_load, holds cnt_inc until cnt_done returns, and
//  reports one status/cycle-count response per request.
//  A shadow model of the counter flags early or late done (timeout) for system-level checking.
// PARAMETERS
//  WIDTH    3   counter width; terminal count TC = 2**WIDTH-1
//  TIMEOUT  16  max RUN cycles without cnt_done before abort; must be >= 2**WIDTH
//  CW       5   width of rsp_cycles; must satisfy 2**CW > TIMEOUT
// PORTS
//  clock       in   1      single clock, rising edge
//  reset       in   1      asynchronous, active-high
//  req_valid   in   1      start request
//  req_ready   out  1      sequencer idle, request accepted when valid&ready
//  req_value   in   WIDTH  start value for counter
//  cnt_load    out  1      load strobe to counter
//  cnt_in      out  WIDTH  value presented with cnt_load
//  cnt_inc     out  1      increment enable to counter
//  cnt_done    in   1      counter at TC (combinational from counter value)
//  rsp_valid   out  1      response available, held until rsp_ready
//  rsp_ready   in   1      response consumed
//  rsp_status  out  2      00 OK, 01 EARLY, 10 TIMEOUT
//  rsp_cycles  out  CW     RUN cycles elapsed before done/abort
//  busy        out  1      state != IDLE
// BEHAVIOUR
//  - All outputs registered. Reset (async) forces state IDLE; all outputs 0 incl. req_ready;
//    req_ready rises the first clock edge after reset deasserts.
//  - FSM IDLE -> LOAD -> RUN -> REPORT -> IDLE.
//  - IDLE: req_ready=1. On req_valid&req_ready capture req_value, req_ready->0, go LOAD.
//  - LOAD (1 cycle): cnt_load=1, cnt_in=captured value, shadow<=value, cycles<=0. -> RUN.
//  - RUN: cnt_inc=1; each cycle without done: shadow<=shadow+1 (wraps mod 2**WIDTH),
//    cycles<=cycles+1. cnt_in holds captured value throughout; cnt_load=0.
//    * cnt_done=1: status OK if shadow==TC, else EARLY; -> REPORT.
//    * cycles==TIMEOUT-1 and no done: status TIMEOUT; -> REPORT.
//    * done and timeout same cycle: done wins.
//  - REPORT: cnt_inc=0 from first REPORT cycle; rsp_valid=1, status/cycles stable
//    until rsp_valid&rsp_ready; then rsp_valid->0, -> IDLE (req_ready=1 next cycle).
//  - Latency: req accept to first cnt_inc = 2 edges; OK run with value v gives rsp_cycles=TC-v.
//  - req_value==TC: done expected in first RUN cycle, rsp_cycles=0, OK.
//  - cnt_done outside RUN ignored. req_valid outside IDLE ignored (no buffering).
//  - Reset mid-operation: drops cnt_inc/cnt_load/rsp_valid immediately; pending request
//    and response discarded.
// STRUCTURE
//  - counter_pkg: status codes ST_OK/ST_EARLY/ST_TIMEOUT, FSM state encodings.
//  - Sub-module counter_model: shadow counter (load, inc, value, at_tc); reusable by
//    the counter bench as reference model. FSM, cycle counter, rsp regs in top.
// TESTING
//  1 Reset: reset=1 mid-RUN -> all outputs 0 same cycle; req_ready=1 one edge after release.
//  2 req_value=0, done driven at TC -> cnt_load 1 cycle, cnt_inc 8 cycles, rsp OK, cycles=7.
//  3 req_value=3'b010 -> rsp OK, cycles=5; rsp_ready held low 4 cycles -> rsp stable,
//    req_valid during REPORT not accepted.
//  4 req_value=0, done forced at shadow=3 -> rsp EARLY, cycles=3, cnt_inc low next cycle.
//  5 done never asserted -> rsp TIMEOUT, cycles=15 after 16 RUN cycles; done+timeout
//    coincident -> OK/EARLY, not TIMEOUT.
//  6 req_value=3'b111 -> done in first RUN cycle, rsp OK, cycles=0; back-to-back requests
//    with rsp_ready=1 -> no lost or duplicated responses.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the counter sequencer slice.
//   ST_*    : response status codes driven on rsp_status
//   state_t : sequencer FSM state encoding
package counter_pkg;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_EARLY   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_RUN    = 2'd2,
    S_REPORT = 2'd3
  } state_t;

endpackage

// File: rtl/counter_model.sv
// Shadow model of the up-counter: loads on i_load, increments (wrapping) on i_inc.
// Ports:
//   clock, reset : clock, async active-high reset
//   i_load       : load strobe (has priority over i_inc)
//   i_value      : value loaded on i_load
//   i_inc        : increment enable
//   o_at_tc      : model value equals terminal count 2**WIDTH-1
module counter_model #(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_inc,
  output logic             o_at_tc
);

  logic [WIDTH-1:0] r_value;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       r_value <= '0;
    else if (i_load) r_value <= i_value;
    else if (i_inc)  r_value <= r_value + 1'b1;
  end

  assign o_at_tc = (r_value == {WIDTH{1'b1}});

endmodule

// File: rtl/counter_sequencer.sv
// Initiator for the up-counter load/inc/done interface. Takes a start value on a
// valid/ready request, pulses cnt_load, holds cnt_inc until cnt_done (or timeout),
// then returns one status/cycle-count response.
// Ports:
//   clock, reset         : clock, async active-high reset
//   req_valid/req_ready  : request handshake, req_value = counter start value
//   cnt_load/cnt_in      : load strobe and load value to the counter
//   cnt_inc/cnt_done     : increment enable to, terminal-count flag from, the counter
//   rsp_valid/rsp_ready  : response handshake
//   rsp_status           : OK / EARLY / TIMEOUT
//   rsp_cycles           : RUN cycles elapsed before done or abort
//   busy                 : sequencer not idle
// All outputs are registered: next values are computed combinationally and
// captured alongside the state.
module counter_sequencer
  import counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_value,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_in,
  output logic             cnt_inc,
  input  logic             cnt_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_status,
  output logic [CW-1:0]    rsp_cycles,
  output logic             busy
);

  localparam logic [CW-1:0] LAST_CYCLE = CW'(TIMEOUT - 1);

  state_t           r_state, w_state_nxt;
  logic             r_req_ready, w_req_ready_nxt;
  logic             r_cnt_load, w_cnt_load_nxt;
  logic [WIDTH-1:0] r_cnt_in, w_cnt_in_nxt;
  logic             r_cnt_inc, w_cnt_inc_nxt;
  logic             r_rsp_valid, w_rsp_valid_nxt;
  logic [1:0]       r_rsp_status, w_rsp_status_nxt;
  logic [CW-1:0]    r_rsp_cycles, w_rsp_cycles_nxt;
  logic [CW-1:0]    r_cycles, w_cycles_nxt;
  logic             r_busy;
  logic             w_at_tc;

  // Shadow tracks what the counter should hold: loaded while LOAD is presented,
  // advanced for every RUN cycle that did not end the run.
  counter_model #(.WIDTH(WIDTH)) u_model (
    .clock   (clock),
    .reset   (reset),
    .i_load  (r_state == S_LOAD),
    .i_value (r_cnt_in),
    .i_inc   ((r_state == S_RUN) && !cnt_done),
    .o_at_tc (w_at_tc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_req_ready_nxt  = 1'b0;
    w_cnt_load_nxt   = 1'b0;
    w_cnt_in_nxt     = r_cnt_in;
    w_cnt_inc_nxt    = 1'b0;
    w_rsp_valid_nxt  = r_rsp_valid;
    w_rsp_status_nxt = r_rsp_status;
    w_rsp_cycles_nxt = r_rsp_cycles;
    w_cycles_nxt     = r_cycles;
    case (r_state)
      S_IDLE: begin
        // req_ready is registered, so the first edge after reset only raises it.
        if (req_valid && r_req_ready) begin
          w_state_nxt    = S_LOAD;
          w_cnt_load_nxt = 1'b1;
          w_cnt_in_nxt   = req_value;
        end else begin
          w_req_ready_nxt = 1'b1;
        end
      end
      S_LOAD: begin
        w_state_nxt   = S_RUN;
        w_cnt_inc_nxt = 1'b1;
        w_cycles_nxt  = '0;
      end
      S_RUN: begin
        // Done takes priority over the timeout on the same cycle.
        if (cnt_done) begin
          w_state_nxt      = S_REPORT;
          w_rsp_valid_nxt  = 1'b1;
          w_rsp_status_nxt = w_at_tc ? ST_OK : ST_EARLY;
          w_rsp_cycles_nxt = r_cycles;
        end else if (r_cycles == LAST_CYCLE) begin
          w_state_nxt      = S_REPORT;
          w_rsp_valid_nxt  = 1'b1;
          w_rsp_status_nxt = ST_TIMEOUT;
          w_rsp_cycles_nxt = r_cycles;
        end else begin
          w_cnt_inc_nxt = 1'b1;
          w_cycles_nxt  = r_cycles + 1'b1;
        end
      end
      S_REPORT: begin
        if (rsp_ready) begin
          w_state_nxt     = S_IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_req_ready_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_req_ready  <= 1'b0;
      r_cnt_load   <= 1'b0;
      r_cnt_in     <= '0;
      r_cnt_inc    <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_status <= '0;
      r_rsp_cycles <= '0;
      r_cycles     <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_req_ready  <= w_req_ready_nxt;
      r_cnt_load   <= w_cnt_load_nxt;
      r_cnt_in     <= w_cnt_in_nxt;
      r_cnt_inc    <= w_cnt_inc_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_status <= w_rsp_status_nxt;
      r_rsp_cycles <= w_rsp_cycles_nxt;
      r_cycles     <= w_cycles_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

  assign req_ready  = r_req_ready;
  assign cnt_load   = r_cnt_load;
  assign cnt_in     = r_cnt_in;
  assign cnt_inc    = r_cnt_inc;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_status = r_rsp_status;
  assign rsp_cycles = r_rsp_cycles;
  assign busy       = r_busy;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: a behavioural counter answers cnt_load/cnt_inc
// and drives cnt_done in one of several modes; a vector table covers the main runs.
module tb_counter_sequencer;

  localparam int WIDTH = 3;
  localparam int CW    = 5;

  localparam int M_TC     = 0;  // done when counter reaches 7
  localparam int M_NEVER  = 1;  // done never asserted
  localparam int M_IDX    = 2;  // done on RUN cycle number didx
  localparam int M_ALWAYS = 3;  // done stuck high

  logic             clock;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_value;
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_in;
  logic             cnt_inc;
  logic             cnt_done;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_status;
  logic [CW-1:0]    rsp_cycles;
  logic             busy;

  int total = 0;
  int bad   = 0;
  int dmode = M_TC;
  int didx  = 0;

  counter_sequencer #(.WIDTH(WIDTH), .TIMEOUT(16), .CW(CW)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_value  (req_value),
    .cnt_load   (cnt_load),
    .cnt_in     (cnt_in),
    .cnt_inc    (cnt_inc),
    .cnt_done   (cnt_done),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_status (rsp_status),
    .rsp_cycles (rsp_cycles),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural counter on the far side of the interface.
  logic [WIDTH-1:0] tb_cnt;
  int               run_idx;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      tb_cnt  <= '0;
      run_idx <= 0;
    end else if (cnt_load) begin
      tb_cnt  <= cnt_in;
      run_idx <= 0;
    end else if (cnt_inc) begin
      tb_cnt  <= tb_cnt + 1'b1;
      run_idx <= run_idx + 1;
    end
  end

  always_comb begin
    cnt_done = 1'b0;
    case (dmode)
      M_TC:     cnt_done = (tb_cnt == 3'd7);
      M_NEVER:  cnt_done = 1'b0;
      M_IDX:    cnt_done = (run_idx == didx);
      default:  cnt_done = 1'b1;
    endcase
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One request/response. hold>0 keeps rsp_ready low that many REPORT cycles while
  // poking req_valid, which must not be taken.
  task automatic run_txn(input int v, input int mode, input int idx, input int hold,
                         output int st, output int cyc, output int nload,
                         output int ninc, output int first_inc);
    int n;
    dmode = mode;
    didx  = idx;
    rsp_ready = (hold == 0);
    n = 0;
    while (!req_ready && n < 20) begin step(); n++; end
    chk("req_ready_before_req", int'(req_ready), 1);
    req_valid = 1'b1;
    req_value = WIDTH'(v);
    step();
    req_valid = 1'b0;
    chk("cnt_in_captured", int'(cnt_in), v);
    nload = 0; ninc = 0; first_inc = -1; n = 0;
    while (!rsp_valid && n < 40) begin
      if (cnt_load) nload++;
      if (cnt_inc) begin
        if (first_inc < 0) first_inc = n;
        ninc++;
      end
      step();
      n++;
    end
    chk("rsp_valid_arrived", int'(rsp_valid), 1);
    chk("cnt_inc_off_in_report", int'(cnt_inc), 0);
    st  = int'(rsp_status);
    cyc = int'(rsp_cycles);
    for (int k = 0; k < hold; k++) begin
      req_valid = 1'b1;
      req_value = 3'd6;
      chk("req_ready_low_in_report", int'(req_ready), 0);
      step();
      chk("rsp_valid_held", int'(rsp_valid), 1);
      chk("rsp_status_stable", int'(rsp_status), st);
      chk("rsp_cycles_stable", int'(rsp_cycles), cyc);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    chk("rsp_valid_dropped", int'(rsp_valid), 0);
    chk("busy_idle_after_rsp", int'(busy), 0);
    chk("req_ready_after_rsp", int'(req_ready), 1);
    if (hold > 0) begin
      rsp_ready = 1'b0;
      step();
      chk("no_buffered_req_load", int'(cnt_load), 0);
      chk("no_buffered_req_busy", int'(busy), 0);
    end
  endtask

  typedef struct {
    int v;
    int mode;
    int idx;
    int hold;
    int exp_st;
    int exp_cyc;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int st, cyc, nl, ni, fi;

    tbl[0] = '{0, M_TC,     0,  0, 0, 7};
    tbl[1] = '{2, M_TC,     0,  4, 0, 5};
    tbl[2] = '{7, M_TC,     0,  0, 0, 0};
    tbl[3] = '{0, M_IDX,    3,  0, 1, 3};
    tbl[4] = '{0, M_NEVER,  0,  0, 2, 15};
    tbl[5] = '{0, M_IDX,    15, 0, 0, 15};  // done+timeout, shadow at 7 -> OK
    tbl[6] = '{1, M_IDX,    15, 0, 1, 15};  // done+timeout, shadow at 0 -> EARLY
    tbl[7] = '{5, M_IDX,    0,  0, 1, 0};
    tbl[8] = '{0, M_ALWAYS, 0,  0, 1, 0};   // done in IDLE/LOAD ignored
    tbl[9] = '{3, M_TC,     0,  0, 0, 4};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_value = '0;
    rsp_ready = 1'b0;
    step();
    step();
    chk("reset_outputs", int'({req_ready, cnt_load, cnt_inc, rsp_valid, busy}), 0);
    chk("reset_status_cycles", int'({rsp_status, rsp_cycles, cnt_in}), 0);
    reset = 1'b0;
    #1;
    chk("req_ready_low_before_edge", int'(req_ready), 0);
    step();
    chk("req_ready_after_release", int'(req_ready), 1);

    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i].v, tbl[i].mode, tbl[i].idx, tbl[i].hold, st, cyc, nl, ni, fi);
      chk($sformatf("v%0d_status", i), st, tbl[i].exp_st);
      chk($sformatf("v%0d_cycles", i), cyc, tbl[i].exp_cyc);
      chk($sformatf("v%0d_load_count", i), nl, 1);
      chk($sformatf("v%0d_inc_count", i), ni, tbl[i].exp_cyc + 1);
      chk($sformatf("v%0d_first_inc", i), fi, 1);
    end

    // Reset in the middle of RUN.
    dmode = M_NEVER;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_value = 3'd0;
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("midrun_inc_high", int'(cnt_inc), 1);
    reset = 1'b1;
    #1;
    chk("midrun_reset_outputs", int'({req_ready, cnt_load, cnt_inc, rsp_valid, busy}), 0);
    step();
    reset = 1'b0;
    #1;
    chk("midrun_req_ready_held_low", int'(req_ready), 0);
    step();
    chk("midrun_req_ready_after_release", int'(req_ready), 1);
    chk("midrun_no_pending_rsp", int'(rsp_valid), 0);

    // Recovery after the aborted run.
    run_txn(0, M_TC, 0, 0, st, cyc, nl, ni, fi);
    chk("recover_status", st, 0);
    chk("recover_cycles", cyc, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
